// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the pipeline MEM stage (port 0)
//   and the loader/debug port (port 1). Round-robin arbitration and one
//   outstanding access at a time. Each access passes through
//   IDLE -> ISSUE -> (WAIT) -> RESP.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   pN_req/we/addr/wdata     request side of port N (word address)
//   pN_gnt                   one-cycle grant pulse (ISSUE cycle)
//   pN_done, pN_err          one-cycle completion pulse, out-of-range flag
//   rdata                    read data, valid with pN_done of a read
//   mem_read/write/addr/wdata/rdata   data memory interface
//   busy                     high whenever an access is in flight
module dmem_arbiter #(
    parameter int unsigned DEPTH  = 10240,
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic        p1_err,
    output logic [31:0] rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic        last_grant;
    logic        lat_port;
    logic        lat_we;
    logic        lat_err;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  cnt;

    logic        win_vld;
    logic        win_port;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        cap;

    // Port 1 wins when alone, or when both request and port 0 was served last.
    always_comb begin
        win_vld   = p0_req | p1_req;
        win_port  = p1_req & (~p0_req | ~last_grant);
        sel_we    = win_port ? p1_we    : p0_we;
        sel_addr  = win_port ? p1_addr  : p0_addr;
        sel_wdata = win_port ? p1_wdata : p0_wdata;
    end

    // Read data is captured on the last cycle the read strobe is high.
    always_comb begin
        cap = ((state == ISSUE) && !lat_we && !lat_err && (RD_LAT == 1)) ||
              ((state == WAIT) && (cnt == 3'd1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_port   <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            rdata      <= '0;
        end else begin
            state <= state_nx;
            if ((state == IDLE) && win_vld) begin
                lat_port   <= win_port;
                lat_we     <= sel_we;
                lat_addr   <= sel_addr;
                lat_wdata  <= sel_wdata;
                lat_err    <= (sel_addr >= 32'(DEPTH));
                last_grant <= win_port;
            end
            if (state == ISSUE) begin
                cnt <= 3'(RD_LAT - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 3'd1;
            end
            if (cap) begin
                rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_done   = 1'b0;
        p1_done   = 1'b0;
        p0_err    = 1'b0;
        p1_err    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (win_vld) state_nx = ISSUE;
            end
            ISSUE: begin
                p0_gnt = ~lat_port;
                p1_gnt = lat_port;
                if (lat_err || lat_we || (RD_LAT == 1)) state_nx = RESP;
                else                                    state_nx = WAIT;
                if (!lat_err) begin
                    mem_addr = lat_addr;
                    if (lat_we) begin
                        mem_write = 1'b1;
                        mem_wdata = lat_wdata;
                    end else begin
                        mem_read = 1'b1;
                    end
                end
            end
            WAIT: begin
                mem_read = 1'b1;
                mem_addr = lat_addr;
                if (cnt <= 3'd1) state_nx = RESP;
            end
            RESP: begin
                p0_done  = ~lat_port;
                p1_done  = lat_port;
                p0_err   = ~lat_port & lat_err;
                p1_err   = lat_port & lat_err;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
